// File: rtl/basic_gate_pkg.sv
// Shared definitions for the basic gate unit: op encoding and default operand width.
package basic_gate_pkg;

    localparam int unsigned DefaultWidth = 1;

    typedef enum logic [1:0] {
        GATE_NOT  = 2'b00,
        GATE_NAND = 2'b01,
        GATE_NOR  = 2'b10,
        GATE_RSVD = 2'b11
    } gate_op_e;

endpackage

// File: rtl/gate_slice.sv
// Combinational NOT/NAND/NOR of two operands plus op-selected result and reserved-op flag.
module gate_slice
    import basic_gate_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  gate_op_e         op_i,
    output logic [Width-1:0] y_not_o,
    output logic [Width-1:0] y_nand_o,
    output logic [Width-1:0] y_nor_o,
    output logic [Width-1:0] y_sel_o,
    output logic             err_o
);

    always_comb begin
        y_not_o  = ~a_i;
        y_nand_o = ~(a_i & b_i);
        y_nor_o  = ~(a_i | b_i);
        y_sel_o  = '0;
        err_o    = 1'b0;
        unique case (op_i)
            GATE_NOT:  y_sel_o = y_not_o;
            GATE_NAND: y_sel_o = y_nand_o;
            GATE_NOR:  y_sel_o = y_nor_o;
            GATE_RSVD: err_o   = 1'b1;
            default:   err_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/basic_gate_unit.sv
// Registered NOT/NAND/NOR unit with selected result and valid qualifier.
// Optional all_zero/all_one status of y_sel when BASIC_GATE_UNIT_FLAGS_EN is defined.
module basic_gate_unit
    import basic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y_not,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor,
    output logic [WIDTH-1:0] y_sel,
    output logic             out_valid,
    output logic             op_err
`ifdef BASIC_GATE_UNIT_FLAGS_EN
    ,
    output logic             all_zero,
    output logic             all_one
`endif
);

    logic [WIDTH-1:0] not_d, nand_d, nor_d, sel_d;
    logic             err_d;

    logic [WIDTH-1:0] not_q, nand_q, nor_q, sel_q;
    logic             err_q, valid_q;

    gate_slice #(
        .Width (WIDTH)
    ) u_gate_slice (
        .a_i      (a),
        .b_i      (b),
        .op_i     (gate_op_e'(op)),
        .y_not_o  (not_d),
        .y_nand_o (nand_d),
        .y_nor_o  (nor_d),
        .y_sel_o  (sel_d),
        .err_o    (err_d)
    );

    // Result registers load only on valid samples, so idle-cycle inputs never reach outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            not_q   <= '0;
            nand_q  <= '0;
            nor_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                not_q  <= not_d;
                nand_q <= nand_d;
                nor_q  <= nor_d;
                sel_q  <= sel_d;
                err_q  <= err_d;
            end
        end
    end

    assign y_not     = not_q;
    assign y_nand    = nand_q;
    assign y_nor     = nor_q;
    assign y_sel     = sel_q;
    assign op_err    = err_q;
    assign out_valid = valid_q;

`ifdef BASIC_GATE_UNIT_FLAGS_EN
    logic all_zero_q, all_one_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_zero_q <= 1'b1;
            all_one_q  <= 1'b0;
        end else if (in_valid) begin
            all_zero_q <= (sel_d == '0);
            all_one_q  <= (sel_d == '1);
        end
    end

    assign all_zero = all_zero_q;
    assign all_one  = all_one_q;
`endif

endmodule

// File: tb/tb_basic_gate_unit.sv
// Bench for basic_gate_unit: 4-bit and 1-bit instances share stimulus (1-bit sees bit 0).
module tb_basic_gate_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b;
    logic [1:0] op;

    logic [3:0] y_not4, y_nand4, y_nor4, y_sel4;
    logic       out_valid4, op_err4;
    logic       y_not1, y_nand1, y_nor1, y_sel1;
    logic       out_valid1, op_err1;
`ifdef BASIC_GATE_UNIT_FLAGS_EN
    logic       all_zero4, all_one4, all_zero1, all_one1;
`endif

    always #5 clk = ~clk;

    basic_gate_unit #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .y_not     (y_not4),
        .y_nand    (y_nand4),
        .y_nor     (y_nor4),
        .y_sel     (y_sel4),
        .out_valid (out_valid4),
        .op_err    (op_err4)
`ifdef BASIC_GATE_UNIT_FLAGS_EN
        ,
        .all_zero  (all_zero4),
        .all_one   (all_one4)
`endif
    );

    basic_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a[0]),
        .b         (b[0]),
        .op        (op),
        .y_not     (y_not1),
        .y_nand    (y_nand1),
        .y_nor     (y_nor1),
        .y_sel     (y_sel1),
        .out_valid (out_valid1),
        .op_err    (op_err1)
`ifdef BASIC_GATE_UNIT_FLAGS_EN
        ,
        .all_zero  (all_zero1),
        .all_one   (all_one1)
`endif
    );

    typedef struct {
        logic [3:0] y_not, y_nand, y_nor, y_sel;
        logic       err;
    } res_t;

    typedef struct {
        logic [3:0] a, b;
        logic [1:0] op;
        res_t       exp;
    } vec_t;

    res_t   sb_q[$];
    res_t   hold;
    bit     exp_v;
    bit     armed;
    int     n_cmp;
    int     n_err;
    vec_t   vecs[11];

    function automatic res_t mk(input logic [3:0] n, input logic [3:0] na, input logic [3:0] no,
                                input logic [3:0] s, input logic e);
        res_t r;
        r.y_not = n; r.y_nand = na; r.y_nor = no; r.y_sel = s; r.err = e;
        return r;
    endfunction

    function automatic res_t model(input logic [3:0] ai, input logic [3:0] bi, input logic [1:0] o);
        res_t r;
        r.y_not  = ~ai;
        r.y_nand = ~(ai & bi);
        r.y_nor  = ~(ai | bi);
        r.err    = (o == 2'b11);
        case (o)
            2'b00:   r.y_sel = r.y_not;
            2'b01:   r.y_sel = r.y_nand;
            2'b10:   r.y_sel = r.y_nor;
            default: r.y_sel = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Checks what the previous edge produced against the scoreboard/held state.
    task automatic check();
        if (!armed) return;
        cmp("out_valid4", {3'b0, out_valid4}, {3'b0, exp_v});
        cmp("out_valid1", {3'b0, out_valid1}, {3'b0, exp_v});
        if (exp_v) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: empty queue at expected output");
            end else begin
                hold = sb_q.pop_front();
            end
        end
        cmp("y_not4",  y_not4,  hold.y_not);
        cmp("y_nand4", y_nand4, hold.y_nand);
        cmp("y_nor4",  y_nor4,  hold.y_nor);
        cmp("y_sel4",  y_sel4,  hold.y_sel);
        cmp("op_err4", {3'b0, op_err4}, {3'b0, hold.err});
        cmp("y_not1",  {3'b0, y_not1},  {3'b0, hold.y_not[0]});
        cmp("y_nand1", {3'b0, y_nand1}, {3'b0, hold.y_nand[0]});
        cmp("y_nor1",  {3'b0, y_nor1},  {3'b0, hold.y_nor[0]});
        cmp("y_sel1",  {3'b0, y_sel1},  {3'b0, hold.y_sel[0]});
        cmp("op_err1", {3'b0, op_err1}, {3'b0, hold.err});
`ifdef BASIC_GATE_UNIT_FLAGS_EN
        cmp("all_zero4", {3'b0, all_zero4}, {3'b0, hold.y_sel == 4'b0000});
        cmp("all_one4",  {3'b0, all_one4},  {3'b0, hold.y_sel == 4'b1111});
        cmp("all_zero1", {3'b0, all_zero1}, {3'b0, hold.y_sel[0] == 1'b0});
        cmp("all_one1",  {3'b0, all_one1},  {3'b0, hold.y_sel[0] == 1'b1});
`endif
    endtask

    // One cycle: check the last edge's outputs, then drive new inputs and record expectations.
    task automatic cycle(input logic rn, input logic v, input logic [3:0] ai, input logic [3:0] bi,
                         input logic [1:0] oi, input res_t e);
        @(negedge clk);
        check();
        rst_n = rn; in_valid = v; a = ai; b = bi; op = oi;
        if (!rn) begin
            sb_q.delete();
            hold  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            exp_v = 1'b0;
            armed = 1'b1;
        end else if (v) begin
            sb_q.push_back(e);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    initial begin
        res_t dc;
        logic [3:0] ra, rb;
        logic [1:0] ro;
        n_cmp = 0; n_err = 0; armed = 0; exp_v = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        dc = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        vecs[0]  = '{4'b0000, 4'b0000, 2'b00, mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0)};
        vecs[1]  = '{4'b1111, 4'b0000, 2'b00, mk(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0)};
        vecs[2]  = '{4'b0001, 4'b0000, 2'b01, mk(4'b1110, 4'b1111, 4'b1110, 4'b1111, 1'b0)};
        vecs[3]  = '{4'b0001, 4'b0001, 2'b01, mk(4'b1110, 4'b1110, 4'b1110, 4'b1110, 1'b0)};
        vecs[4]  = '{4'b0000, 4'b0001, 2'b10, mk(4'b1111, 4'b1111, 4'b1110, 4'b1110, 1'b0)};
        vecs[5]  = '{4'b0000, 4'b0000, 2'b10, mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0)};
        vecs[6]  = '{4'b1010, 4'b0110, 2'b00, mk(4'b0101, 4'b1101, 4'b0001, 4'b0101, 1'b0)};
        vecs[7]  = '{4'b1010, 4'b0110, 2'b01, mk(4'b0101, 4'b1101, 4'b0001, 4'b1101, 1'b0)};
        vecs[8]  = '{4'b1010, 4'b0110, 2'b10, mk(4'b0101, 4'b1101, 4'b0001, 4'b0001, 1'b0)};
        vecs[9]  = '{4'b1010, 4'b0110, 2'b11, mk(4'b0101, 4'b1101, 4'b0001, 4'b0000, 1'b1)};
        vecs[10] = '{4'b1100, 4'b1010, 2'b01, mk(4'b0011, 4'b0111, 4'b0001, 4'b0111, 1'b0)};

        // Reset, then idle cycles: reset values must be visible.
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);

        // Directed table, back-to-back valids.
        for (int i = 0; i < 11; i++)
            cycle(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

        // Hold with X inputs while idle.
        cycle(1'b1, 1'b0, 4'bxxxx, 4'bxxxx, 2'bxx, dc);
        cycle(1'b1, 1'b0, 4'bxxxx, 4'bxxxx, 2'bxx, dc);

        // Reset wins over in_valid on the same edge.
        cycle(1'b1, 1'b1, vecs[6].a, vecs[6].b, vecs[6].op, vecs[6].exp);
        cycle(1'b0, 1'b1, vecs[0].a, vecs[0].b, vecs[0].op, dc);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);

        // First valid after release yields out_valid on the following edge.
        cycle(1'b1, 1'b1, vecs[9].a, vecs[9].b, vecs[9].op, vecs[9].exp);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);

        // Random back-to-back stream.
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); ro = 2'($urandom);
            cycle(1'b1, 1'b1, ra, rb, ro, model(ra, rb, ro));
        end
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, dc);

        if (sb_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/basic_gate_unit.md
# basic_gate_unit

Registered bitwise logic-gate unit providing NOT, NAND and NOR results of two WIDTH-bit operands. All three results are always computed in parallel. A selected result is also provided with a valid qualifier. It sits as a small datapath leaf behind a register-slice boundary, so consumers see clean, clock-aligned outputs.

## Interface
- WIDTH, default 1: operand/result width in bits (legal 1..64).
- clk  input  1  rising-edge clock.
- rst_n  input  1  one clock; reset is synchronous and active-low.
- in_valid  input  1  operands and op are sampled when high.
- a  input  WIDTH  first operand (NOT uses a only).
- b  input  WIDTH  second operand.
- op  input  2  result select: 2'b00 NOT, 2'b01 NAND, 2'b10 NOR, 2'b11 reserved.
- y_not  output  WIDTH  registered ~a.
- y_nand  output  WIDTH  registered ~(a & b).
- y_nor  output  WIDTH  registered ~(a | b).
- y_sel  output  WIDTH  registered result chosen by op.
- out_valid  output  1  y_* updated this cycle from a valid sample.
- op_err  output  1  registered; high when the sampled op was 2'b11.
- all_zero, all_one  output  1 each  status of y_sel; present only with BASIC_GATE_UNIT_FLAGS_EN.

## Operation
- On a rising clk with rst_n=1 and in_valid=1:
  - y_not <= ~a, y_nand <= ~(a&b), y_nor <= ~(a|b). All are pure bitwise operations, with no carries and no cross-bit interaction.
  - y_sel <= the op-selected result. For op=2'b11, y_sel <= all zeros and op_err <= 1. For any other op, op_err <= 0.
  - out_valid <= 1.
- On a rising clk with rst_n=1 and in_valid=0:
  - y_not, y_nand, y_nor, y_sel and op_err hold their values.
  - out_valid <= 0.
- Inputs are ignored when in_valid=0. X on a, b or op while in_valid=0 must not propagate.
- There is no backpressure. Every valid sample produces exactly one out_valid pulse.

## Timing
- Latency is exactly 1 cycle from the in_valid sample edge to outputs. Throughput is one result per cycle; back-to-back valids give back-to-back out_valid.
- Reset values (rst_n low at a clk edge): y_not, y_nand, y_nor, y_sel = 0; out_valid = 0; op_err = 0; all_zero = 1; all_one = 0.
- Reset wins over in_valid on the same edge, and no result from that sample is produced.
- Reset asserted mid-stream discards the pending result. The first valid sample after release produces out_valid on the following edge.
- Outputs change only on clk edges. There are no combinational paths from inputs to outputs.

## Configuration
- BASIC_GATE_UNIT_FLAGS_EN defined: the all_zero and all_one ports exist.
  - They are registered together with y_sel: all_zero = (next y_sel == 0), all_one = (next y_sel == all ones).
  - They update only on valid samples.
- BASIC_GATE_UNIT_FLAGS_EN undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package basic_gate_pkg holds:
  - the op encoding as a 2-bit enum: GATE_NOT, GATE_NAND, GATE_NOR, GATE_RSVD;
  - a localparam for the default width.
- One sub-module, gate_slice. It is combinational: it takes a, b and op and returns not/nand/nor/sel/err. It is instantiated once at full WIDTH.
- The top level holds only the output register stage, the valid pipeline and the optional flags.

## Test plan
- WIDTH=1, NOT: a=0 -> y_not=1 one cycle later; then a=1 -> y_not=0. out_valid=1 on each.
- WIDTH=1, NAND: a=1,b=0 -> y_nand=1; a=1,b=1 -> y_nand=0. With op=01, y_sel matches y_nand.
- WIDTH=1, NOR: a=0,b=1 -> y_nor=0; a=0,b=0 -> y_nor=1. With op=10, y_sel matches y_nor.
- WIDTH=4:
  - a=1010, b=0110 -> y_not=0101, y_nand=1101, y_nor=0001.
  - op=11 -> y_sel=0000, op_err=1.
  - With flags enabled, all_zero=1.
- Reset and hold:
  - rst_n=0 with in_valid=1 -> all outputs at reset values next edge.
  - Valid sample followed by in_valid=0 and X inputs -> y_* hold, out_valid=0.
- Streaming: random a, b, op for 1000 back-to-back valid cycles -> every output matches the bitwise model exactly one cycle later.
